// File: rtl/wb_uart_rx_pkg.sv
// Shared definitions for the Wishbone UART receiver: register offsets,
// STATUS bit positions, receiver FSM encoding and oversampling constants.
package wb_uart_rx_pkg;

  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] SC_HALF = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SC_LAST = 4'(OVERSAMPLE - 1);

  localparam logic [1:0] UART_RX_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_RX_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_RX_REG_DIV    = 2'd2;
  localparam logic [1:0] UART_RX_REG_CLR    = 2'd3;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVR       = 2;
  localparam int ST_FERR      = 3;
  localparam int ST_PERR      = 4;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_e;

  // True when data plus received parity bit match the selected parity sense.
  function automatic logic parity_ok(logic [7:0] data, logic pbit, logic odd);
    return (^{data, pbit}) == odd;
  endfunction

endpackage

// File: rtl/wb_uart_rx_fifo.sv
// Synchronous FIFO for received bytes. A pop in the same clock as a push
// on a full FIFO frees the slot first, so that push is accepted.
module wb_uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = count[AW];
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign drop     = push & full & ~do_pop;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart_rx.sv
// Wishbone UART receiver: 16x oversampled 8N1 deserialiser feeding a byte
// FIFO read out through four word registers (DATA, STATUS, DIV, CLR).
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module wb_uart_rx
  import wb_uart_rx_pkg::*;
#(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int DEFAULT_DIV   = 26
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  input  logic                     uart_rx_i,
  output logic                     rx_irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            sync_p0, sync_p1, rxs;
  logic [15:0]     div_q, tick_cnt;
  logic            tick, tick_clr;
  rx_state_e       state_q, state_d;
  logic [3:0]      sc_q, sc_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            push, ferr_set, perr_set;
  logic [7:0]      fifo_rdata;
  logic            fifo_full, fifo_empty, ovr_set, pop;
  logic [CW-1:0]   fifo_count;
  logic            ovr_q, ferr_q, perr_q, podd;
  logic            req, rd, wr, div_wr, clr_wr;
  logic [1:0]      reg_sel;
  logic [WB_DATA_WIDTH-1:0] rdata;
  logic            unused_bits;

`ifdef UART_RX_PARITY_EN
  logic podd_q;
  assign podd        = podd_q;
  assign unused_bits = ^{wb_sel_i, wb_addr_i[WB_ADDR_WIDTH-1:4], wb_addr_i[1:0],
                         wb_data_i[WB_DATA_WIDTH-1:17], wb_data_i[7:5], wb_data_i[1:0]};
`else
  assign podd        = 1'b0;
  assign unused_bits = ^{wb_sel_i, wb_addr_i[WB_ADDR_WIDTH-1:4], wb_addr_i[1:0],
                         wb_data_i[WB_DATA_WIDTH-1:16], wb_data_i[7:5], wb_data_i[1:0]};
`endif

  // Stage p0/p1: two-flop synchroniser on the asynchronous serial pin.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= uart_rx_i;
      sync_p1 <= sync_p0;
    end
  end
  assign rxs = sync_p1;

  // Oversample tick: one pulse every DIV+1 clocks, restarted on demand.
  assign tick = (tick_cnt == div_q);
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                     tick_cnt <= '0;
    else if (div_wr || tick_clr || tick) tick_cnt <= '0;
    else                              tick_cnt <= tick_cnt + 16'd1;
  end

  // Receiver FSM state and counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      sc_q    <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bit_q   <= bit_d;
    end
  end

  // Shift register holds payload only, so it carries no reset.
  always_ff @(posedge clk_i) begin
    shreg_q <= shreg_d;
  end

  // Receiver FSM next-state and event outputs.
  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    tick_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d  = S_START;
          sc_d     = '0;
          tick_clr = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (sc_q == SC_HALF) begin
            if (rxs) begin
              state_d = S_IDLE;
            end else begin
              sc_d    = '0;
              bit_d   = '0;
              state_d = S_DATA;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sc_d = sc_q + 4'd1;
          if (sc_q == SC_LAST) begin
            shreg_d = {rxs, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
      end
      S_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (tick) begin
          sc_d = sc_q + 4'd1;
          if (sc_q == SC_LAST) begin
            perr_set = ~parity_ok(shreg_q, rxs, podd);
            state_d  = S_STOP;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_STOP: begin
        if (tick) begin
          sc_d = sc_q + 4'd1;
          if (sc_q == SC_LAST) begin
            if (rxs) begin
              push    = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_set = 1'b1;
              state_d  = S_BREAK;
            end
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  wb_uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .push      (push),
    .push_data (shreg_q),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (ovr_set)
  );

  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign rd      = req & ~wb_we_i;
  assign wr      = req & wb_we_i;
  assign reg_sel = wb_addr_i[3:2];
  assign div_wr  = wr && (reg_sel == UART_RX_REG_DIV);
  assign clr_wr  = wr && (reg_sel == UART_RX_REG_CLR);
  assign pop     = rd && (reg_sel == UART_RX_REG_DATA) && !fifo_empty;

  // Register read multiplexer.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      UART_RX_REG_DATA:   rdata = fifo_empty ? '0 : WB_DATA_WIDTH'(fifo_rdata);
      UART_RX_REG_STATUS: rdata = WB_DATA_WIDTH'({8'(fifo_count), 3'b000, perr_q,
                                                  ferr_q, ovr_q, fifo_full, ~fifo_empty});
      UART_RX_REG_DIV:    rdata = WB_DATA_WIDTH'({podd, div_q});
      default:            rdata = '0;
    endcase
  end

  // Single-clock registered acknowledge with its read data.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_ack_o  <= 1'b0;
      wb_data_o <= '0;
    end else begin
      wb_ack_o  <= req;
      wb_data_o <= rd ? rdata : '0;
    end
  end

  // Divisor register (and parity sense when parity is built in).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q <= 16'(DEFAULT_DIV);
`ifdef UART_RX_PARITY_EN
      podd_q <= 1'b0;
`endif
    end else if (div_wr) begin
      div_q <= wb_data_i[15:0];
`ifdef UART_RX_PARITY_EN
      podd_q <= wb_data_i[16];
`endif
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_set  | (ovr_q  & ~(clr_wr & wb_data_i[ST_OVR]));
      ferr_q <= ferr_set | (ferr_q & ~(clr_wr & wb_data_i[ST_FERR]));
      perr_q <= perr_set | (perr_q & ~(clr_wr & wb_data_i[ST_PERR]));
    end
  end

  // Interrupt follows FIFO occupancy one clock later.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rx_irq_o <= 1'b0;
    else          rx_irq_o <= ~fifo_empty;
  end

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed testbench for wb_uart_rx. Frames are sent at DIV=3 (64 clocks
// per bit). Build with UART_RX_PARITY_EN defined to include the parity test.
module tb_wb_uart_rx;

  localparam int BIT = 64;
  localparam logic [31:0] A_DATA = 32'h0, A_STATUS = 32'h4, A_DIV = 32'h8, A_CLR = 32'hC;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [31:0] wb_addr_i;
  logic [31:0] wb_data_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_stb_i, wb_cyc_i;
  logic        wb_ack_o;
  logic [31:0] wb_data_o;
  logic        uart_rx_i;
  logic        rx_irq_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  wb_uart_rx dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n_i),
    .wb_addr_i (wb_addr_i),
    .wb_data_i (wb_data_i),
    .wb_sel_i  (wb_sel_i),
    .wb_we_i   (wb_we_i),
    .wb_stb_i  (wb_stb_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_ack_o  (wb_ack_o),
    .wb_data_o (wb_data_o),
    .uart_rx_i (uart_rx_i),
    .rx_irq_o  (rx_irq_o)
  );

  task automatic wb_access(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] data);
    bit got = 0;
    data = '0;
    @(posedge clk); #1;
    wb_addr_i = addr; wb_data_i = wdata; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        got  = 1;
        data = wb_data_o;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (!got) begin
      errors++; checks++;
      $display("FAIL wb_ack_timeout addr=%h got no ack required ack within 8 clocks", addr);
    end
  endtask

  task automatic wb_read(input logic [31:0] addr, output logic [31:0] data);
    wb_access(1'b0, addr, 32'h0, data);
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    wb_access(1'b1, addr, data, dummy);
  endtask

  task automatic line(input logic v, input int n);
    uart_rx_i = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  // Start bit, 8 data bits LSB first and, when built in, a parity bit.
  task automatic send_head(input logic [7:0] b, input logic pbit);
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(b[i], BIT);
`ifdef UART_RX_PARITY_EN
    line(pbit, BIT);
`else
    if (pbit) begin end
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_head(b, even_par(b));
    line(1'b1, BIT);
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0; uart_rx_i = 1'b1;
    wb_addr_i = '0; wb_data_i = '0; wb_sel_i = 4'hF;
    wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    repeat (5) @(posedge clk); #1;
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", wb_ack_o); end
    checks++; if (wb_data_o !== 32'h0) begin errors++; $display("FAIL reset_data_o got %h want 0", wb_data_o); end
    checks++; if (rx_irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", rx_irq_o); end
    rst_n_i = 1'b1;
    repeat (2) @(posedge clk); #1;
    wb_read(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", rd); end
    wb_read(A_DIV, rd);
    checks++; if (rd !== 32'd26) begin errors++; $display("FAIL reset_div got %h want 1a", rd); end
    wb_read(A_DATA, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_data_empty got %h want 0", rd); end
    wb_write(A_DATA, 32'hFF);
    wb_read(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL data_write_ignored got %h want 0", rd); end
    wb_read(A_CLR, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL clr_read got %h want 0", rd); end
  endtask

  // Holding the strobe gives an ack every other clock.
  task automatic test_back_to_back;
    @(posedge clk); #1;
    wb_addr_i = A_DIV; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    checks++; if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got %b want 1", wb_ack_o); end
    checks++; if (wb_data_o !== 32'd26) begin errors++; $display("FAIL b2b_data1 got %h want 1a", wb_data_o); end
    @(posedge clk); #1;
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b want 0", wb_ack_o); end
    @(posedge clk); #1;
    checks++; if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got %b want 1", wb_ack_o); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic test_div;
    logic [31:0] exp;
`ifdef UART_RX_PARITY_EN
    exp = 32'h0001_0003;
`else
    exp = 32'h0000_0003;
`endif
    wb_write(A_DIV, 32'hFFFF_0003);
    wb_read(A_DIV, rd);
    checks++; if (rd !== exp) begin errors++; $display("FAIL div_upper got %h want %h", rd, exp); end
    wb_write(A_DIV, 32'h3);
    wb_read(A_DIV, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL div_write got %h want 3", rd); end
  endtask

  task automatic test_single_byte;
    send_head(8'hA5, even_par(8'hA5));
    uart_rx_i = 1'b1;
    repeat (20) @(posedge clk); #1;
    checks++; if (rx_irq_o !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", rx_irq_o); end
    repeat (44) @(posedge clk); #1;
    checks++; if (rx_irq_o !== 1'b1) begin errors++; $display("FAIL irq_after_stop got %b want 1", rx_irq_o); end
    wb_read(A_STATUS, rd);
    checks++; if (rd !== 32'h0101) begin errors++; $display("FAIL single_status got %h want 101", rd); end
    wb_read(A_DATA, rd);
    checks++; if (rd !== 32'hA5) begin errors++; $display("FAIL single_data got %h want a5", rd); end
    wb_read(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL single_status_after got %h want 0", rd); end
    checks++; if (rx_irq_o !== 1'b0) begin errors++; $display("FAIL single_irq_after got %b want 0", rx_irq_o); end
  endtask

  task automatic test_glitch;
    line(1'b0, 20);
    line(1'b1, 100);
    wb_read(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL glitch_status got %h want 0", rd); end
    checks++; if (rx_irq_o !== 1'b0) begin errors++; $display("FAIL glitch_irq got %b want 0", rx_irq_o); end
  endtask

  task automatic test_overrun;
    for (int i = 0; i <= 16; i++) send_byte(8'(i));
    wb_read(A_STATUS, rd);
    checks++; if (rd !== 32'h1007) begin errors++; $display("FAIL ovr_status got %h want 1007", rd); end
    for (int i = 0; i < 16; i++) begin
      wb_read(A_DATA, rd);
      checks++;
      if (rd !== 32'(i)) begin errors++; $display("FAIL ovr_data%0d got %h want %h", i, rd, 32'(i)); end
    end
    wb_read(A_STATUS, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL ovr_sticky got %h want 4", rd); end
    wb_write(A_CLR, 32'h4);
    wb_read(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ovr_clear got %h want 0", rd); end
  endtask

  task automatic test_framing;
    send_head(8'h3C, even_par(8'h3C));
    line(1'b0, 3 * BIT);
    line(1'b1, BIT);
    wb_read(A_STATUS, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL ferr_status got %h want 8", rd); end
    wb_read(A_DATA, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ferr_no_push got %h want 0", rd); end
    send_byte(8'h11);
    wb_read(A_STATUS, rd);
    checks++; if (rd !== 32'h0109) begin errors++; $display("FAIL ferr_next_status got %h want 109", rd); end
    wb_read(A_DATA, rd);
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL ferr_next_data got %h want 11", rd); end
    wb_write(A_CLR, 32'h8);
    wb_read(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ferr_clear got %h want 0", rd); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    send_head(8'h07, 1'b0);
    line(1'b1, BIT);
    wb_read(A_STATUS, rd);
    checks++; if (rd !== 32'h0111) begin errors++; $display("FAIL perr_status got %h want 111", rd); end
    wb_read(A_DATA, rd);
    checks++; if (rd !== 32'h07) begin errors++; $display("FAIL perr_data got %h want 7", rd); end
    wb_write(A_CLR, 32'h10);
    wb_read(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL perr_clear got %h want 0", rd); end
  endtask
`endif

  initial begin
    test_reset;
    test_back_to_back;
    test_div;
    test_single_byte;
    test_glitch;
    test_overrun;
    test_framing;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
